seg_frame_builder: RTL and testbench

Builds the 64-bit segment frame for the 8-digit serial seven-segment display and presents it on `pdata` to the downstream serializer. It accepts a binary value on a load strobe and formats it in hex or decimal. Decimal conversion uses an iterative double-dabble. The block also applies per-digit decimal points, leading-zero blanking and per-digit blinking. The serializer re-samples `pdata` continuously, so `pdata` must always hold a complete, glitch-free frame.

---
 rtl/seg_frame_if.sv | 26 ++
 rtl/seg_frame_builder.sv | 153 +++++++++++++++
 tb/tb_seg_frame_builder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_frame_if.sv
// Handshake and frame bus between the display controller and seg_frame_builder.
// The master drives the load request and display options; the slave returns the frame and status.
interface seg_frame_if #(
  parameter int BIN_W = 27
);
  logic             load;
  logic [BIN_W-1:0] value;
  logic             hex_mode;
  logic [7:0]       dp;
  logic             blank_lz;
  logic [7:0]       blink_mask;
  logic [63:0]      pdata;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output load, value, hex_mode, dp, blank_lz, blink_mask,
    input  pdata, busy, done, ovf
  );

  modport slave (
    input  load, value, hex_mode, dp, blank_lz, blink_mask,
    output pdata, busy, done, ovf
  );
endinterface

// File: rtl/seg_frame_builder.sv
// Formats a binary value as an 8-digit seven-segment frame (hex or double-dabble decimal)
// with decimal points, leading-zero blanking and per-digit blinking on a registered output.
module seg_frame_builder #(
  parameter int BIN_W      = 27,
  parameter int BLINK_BITS = 24
) (
  input logic        clk,
  input logic        rst,
  seg_frame_if.slave bus
);
  localparam int          CNT_W   = $clog2(BIN_W);
  localparam logic [31:0] DEC_MAX = 32'd99_999_999;

  typedef enum logic [1:0] {IDLE, CONV, ENC} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt_p0;
  logic [BIN_W-1:0]      bin_p0;
  logic [31:0]           bcd_p0;
  logic                  hex_p0, blz_p0, dovf_p0;
  logic [7:0]            dp_p0;
  logic [63:0]           shadow_p1, shadow_nxt;
  logic                  commit_p1;
  logic [63:0]           pdata_p2, pdata_nxt;
  logic                  done_p2;
  logic                  ovf_r;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  busy_c, enc_c, accept_c, ovf_in_c;

  function automatic logic [31:0] add3(input logic [31:0] bcd);
    logic [31:0] r;
    r = bcd;
    for (int i = 0; i < 8; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  assign accept_c = (state == IDLE) && bus.load;
  assign ovf_in_c = !bus.hex_mode && (32'(bus.value) > DEC_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load) state_nxt = (bus.hex_mode || ovf_in_c) ? ENC : CONV;
      CONV:    if (cnt_p0 == CNT_W'(BIN_W - 1)) state_nxt = ENC;
      ENC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state != IDLE);
    enc_c  = (state == ENC);
  end

  // Stage p0: latch request and run the double-dabble shift
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0  <= '0;
      bin_p0  <= '0;
      bcd_p0  <= '0;
      hex_p0  <= 1'b0;
      blz_p0  <= 1'b0;
      dovf_p0 <= 1'b0;
      dp_p0   <= '0;
    end else if (accept_c) begin
      cnt_p0  <= '0;
      bin_p0  <= bus.value;
      bcd_p0  <= '0;
      hex_p0  <= bus.hex_mode;
      blz_p0  <= bus.blank_lz;
      dovf_p0 <= ovf_in_c;
      dp_p0   <= bus.dp;
    end else if (state == CONV) begin
      {bcd_p0, bin_p0} <= {add3(bcd_p0), bin_p0} << 1;
      cnt_p0           <= cnt_p0 + 1'b1;
    end
  end

  // Digits above the most significant non-zero nibble are leading zeros; digit 0 always shows
  always_comb begin
    logic [31:0] nib;
    logic        lead;
    logic [7:0]  seg;
    shadow_nxt = '1;
    nib        = hex_p0 ? 32'(bin_p0) : bcd_p0;
    lead       = 1'b1;
    seg        = 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      if (nib[4*i +: 4] != 4'd0) lead = 1'b0;
      seg = glyph(nib[4*i +: 4]);
      if (blz_p0 && lead && (i != 0)) seg = 8'hFF;
      if (dovf_p0) seg = 8'hBF;
      if (dp_p0[i]) seg[7] = 1'b0;
      shadow_nxt[8*i +: 8] = seg;
    end
  end

  // Stage p1: commit the encoded frame to the shadow register
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_p1 <= '1;
      commit_p1 <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      commit_p1 <= enc_c;
      if (enc_c) begin
        shadow_p1 <= shadow_nxt;
        ovf_r     <= dovf_p0;
      end
    end
  end

  always_comb begin
    pdata_nxt = shadow_p1;
    for (int i = 0; i < 8; i++) begin
      if (bus.blink_mask[i] && blink_cnt[BLINK_BITS-1]) pdata_nxt[8*i +: 8] = 8'hFF;
    end
  end

  // Stage p2: whole-frame output register with live blink masking
  always_ff @(posedge clk) begin
    if (rst) begin
      pdata_p2  <= '1;
      done_p2   <= 1'b0;
      blink_cnt <= '0;
    end else begin
      pdata_p2  <= pdata_nxt;
      done_p2   <= commit_p1;
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign bus.pdata = pdata_p2;
  assign bus.busy  = busy_c;
  assign bus.done  = done_p2;
  assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_seg_frame_builder.sv
// Randomized bench for seg_frame_builder against a digit-level reference model.
module tb_seg_frame_builder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  logic [63:0] exp_frame = '1;
  bit          exp_ovf   = 1'b0;
  logic [7:0]  glyph_t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_frame_if #(.BIN_W(27)) bus ();

  seg_frame_builder #(.BIN_W(27), .BLINK_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  function automatic logic [63:0] model_frame(input logic [26:0] v, input bit hx,
                                              input logic [7:0] d, input bit blz, output bit ov);
    int          digs [8];
    int          msd;
    longint      x;
    logic [7:0]  b;
    logic [63:0] f;
    ov  = !hx && (v > 27'd99_999_999);
    x   = longint'(v);
    msd = 0;
    for (int i = 0; i < 8; i++) begin
      if (hx) begin
        digs[i] = int'(x % 16);
        x       = x / 16;
      end else begin
        digs[i] = int'(x % 10);
        x       = x / 10;
      end
      if (digs[i] != 0) msd = i;
    end
    for (int i = 0; i < 8; i++) begin
      if (ov)                  b = 8'hBF;
      else if (blz && i > msd) b = 8'hFF;
      else                     b = glyph_t[digs[i]];
      if (d[i]) b[7] = 1'b0;
      f[8*i +: 8] = b;
    end
    return f;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or after the bound).
  task automatic do_load(input logic [26:0] v, input bit hx, input logic [7:0] d,
                         input bit blz, input int poke_at, input string nm);
    logic [63:0] ef;
    bit          eo;
    bit          busy_ok;
    int          lat;
    int          i;
    ef  = model_frame(v, hx, d, blz, eo);
    lat = (hx || eo) ? 2 : 29;
    bus.load = 1'b1; bus.value = v; bus.hex_mode = hx; bus.dp = d; bus.blank_lz = blz;
    @(negedge clk);
    bus.load = 1'b0; bus.value = 27'($urandom); bus.hex_mode = 1'($urandom);
    bus.dp = 8'($urandom); bus.blank_lz = 1'($urandom);
    busy_ok = 1'b1;
    i = 0;
    while (!bus.done && i < 40) begin
      if (i <= lat - 2 && bus.busy !== 1'b1) busy_ok = 1'b0;
      if (poke_at > 0 && i == poke_at)     bus.load = 1'b1;
      if (poke_at > 0 && i == poke_at + 1) bus.load = 1'b0;
      @(negedge clk);
      i++;
    end
    bus.load = 1'b0;
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout done=%b required=1 within 40 cycles", nm, bus.done);
    end else begin
      total += 3;
      if (i != lat) begin
        bad++;
        $display("FAIL %s_latency got=%0d required=%0d", nm, i, lat);
      end
      if (bus.pdata !== ef) begin
        bad++;
        $display("FAIL %s_pdata got=%h required=%h", nm, bus.pdata, ef);
      end
      if (bus.ovf !== eo) begin
        bad++;
        $display("FAIL %s_ovf got=%b required=%b", nm, bus.ovf, eo);
      end
      if (!busy_ok) begin
        bad++;
        $display("FAIL %s_busy got=0 required=1 during conversion", nm);
      end
    end
    exp_frame = ef;
    exp_ovf   = eo;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total += 4;
    if (bus.pdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL reset_pdata got=%h required=all FF", bus.pdata); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b required=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b required=0", bus.done); end
    if (bus.ovf  !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b required=0", bus.ovf); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.pdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL reset_hold got=%h required=all FF", bus.pdata); end
    exp_frame = '1;
    exp_ovf   = 1'b0;
  endtask

  task automatic test_hex();
    do_load(27'h1234ABC, 1'b1, 8'h00, 1'b0, 0, "hex_vec");
    @(negedge clk);
    total += 2;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL hex_done_pulse got=%b required=0", bus.done); end
    if (bus.pdata !== 64'hC0F9_A4B0_9988_83C6) begin bad++; $display("FAIL hex_const got=%h required=c0f9a4b0998883c6", bus.pdata); end
  endtask

  task automatic test_decimal();
    do_load(27'd12345, 1'b0, 8'h04, 1'b1, 0, "dec_vec");
    total++;
    if (bus.pdata !== 64'hFFFF_FFF9_A430_9992) begin bad++; $display("FAIL dec_const got=%h required=fffffff9a4309992", bus.pdata); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    do_load(27'd100_000_000, 1'b0, 8'h81, 1'b0, 0, "ovf_set");
    @(negedge clk);
    do_load(27'd0, 1'b0, 8'h00, 1'b1, 0, "ovf_clear");
    total++;
    if (bus.pdata !== 64'hFFFF_FFFF_FFFF_FFC0) begin bad++; $display("FAIL zero_const got=%h required=ffffffffffffffc0", bus.pdata); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy_load();
    do_load(27'd87_654_321, 1'b0, 8'h10, 1'b1, 10, "ignore");
    repeat (4) @(negedge clk);
    total++;
    if (bus.pdata !== exp_frame || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_hold pdata=%h busy=%b required=%h busy=0", bus.pdata, bus.busy, exp_frame);
    end
  endtask

  task automatic test_reset_abort();
    bit seen_done;
    bus.load = 1'b1; bus.value = 27'd4321; bus.hex_mode = 1'b0; bus.dp = 8'h00; bus.blank_lz = 1'b0;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    exp_frame = '1;
    exp_ovf   = 1'b0;
    total += 3;
    if (seen_done) begin bad++; $display("FAIL abort_done got=1 required=0"); end
    if (bus.pdata !== exp_frame) begin bad++; $display("FAIL abort_pdata got=%h required=all FF", bus.pdata); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b required=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    do_load(27'($urandom), 1'b1, 8'($urandom), 1'($urandom), 0, "b2b_first");
    do_load(27'($urandom_range(99_999_999)), 1'b0, 8'($urandom), 1'($urandom), 0, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [26:0] v;
    bit          hx;
    for (int n = 0; n < 12; n++) begin
      hx = 1'($urandom);
      case ($urandom_range(2))
        0:       v = 27'($urandom_range(999));
        1:       v = 27'($urandom_range(99_999_999));
        default: v = 27'($urandom_range(134_217_727, 100_000_000));
      endcase
      do_load(v, hx, 8'($urandom), 1'($urandom), 0, "rand");
      repeat ($urandom_range(1, 4)) @(negedge clk);
      total++;
      if (bus.pdata !== exp_frame || bus.ovf !== exp_ovf) begin
        bad++;
        $display("FAIL rand_hold pdata=%h ovf=%b required=%h ovf=%b", bus.pdata, bus.ovf, exp_frame, exp_ovf);
      end
    end
  endtask

  task automatic test_blink();
    logic [7:0] eb;
    do_load(27'd0, 1'b1, 8'h00, 1'b0, 0, "blink_load");
    bus.blink_mask = 8'h01;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      eb = (((edge_n - 1) >> 3) & 1) != 0 ? 8'hFF : 8'hC0;
      total++;
      if (bus.pdata[7:0] !== eb || bus.pdata[63:8] !== exp_frame[63:8]) begin
        bad++;
        $display("FAIL blink cycle=%0d got=%h required=%h_%h", i, bus.pdata, exp_frame[63:8], eb);
      end
    end
    bus.blink_mask = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    bus.load = 1'b0; bus.value = '0; bus.hex_mode = 1'b0; bus.dp = '0;
    bus.blank_lz = 1'b0; bus.blink_mask = '0;
    @(negedge clk);
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_ignore_busy_load();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_blink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
